pc_sequencer: RTL

//  Program-counter sequencer for the 19-bit CPU. Drives the instruction memory address and

---
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Bundles the fetch/control signals of the program-counter sequencer.
//   master : sequencer side (drives pc/advance/depth/fault)
//   slave  : environment side (instruction memory, register-file comparator,
//            pipeline stall source)
//   Signals:
//     stall      1 = hold PC this cycle
//     instr      19-bit word at mem[pc]
//     branch_eq  rs==rt compare for the current instruction
//     pc         registered fetch address
//     advance    registered pulse, PC updated on previous edge
//     depth      return-address stack occupancy
//     fault      latched stack fault (0 unless STACK_FAULT_EN build)
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int unsigned STACK_DEPTH = 8
);
   localparam int unsigned DW = $clog2(STACK_DEPTH) + 1;

   logic          stall;
   logic [18:0]   instr;
   logic          branch_eq;
   logic [18:0]   pc;
   logic          advance;
   logic [DW-1:0] depth;
   logic          fault;

   modport master (
      input  stall, instr, branch_eq,
      output pc, advance, depth, fault
   );

   modport slave (
      output stall, instr, branch_eq,
      input  pc, advance, depth, fault
   );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the 19-bit CPU. Drives the instruction
//   memory address, decodes BEQ/BNE/JMP/CALL/RET and keeps a hardware
//   return-address stack for CALL/RET.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   pc_sequencer_if.master (stall, instr, branch_eq in;
//           pc, advance, depth, fault out)
//   Parameters:
//     RESET_PC     PC loaded on reset
//     STACK_DEPTH  return-address stack entries (>=2, power of two)
//   Build option:
//     STACK_FAULT_EN  when defined, stack overflow/underflow freezes the
//                     sequencer in FAULT until reset; otherwise overflow
//                     drops the push and underflow returns to RESET_PC.
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [18:0] RESET_PC    = 19'd0,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.master bus
);

   localparam int unsigned AW = $clog2(STACK_DEPTH);
   localparam int unsigned DW = AW + 1;

   localparam logic [4:0] OP_BEQ  = 5'b00011;
   localparam logic [4:0] OP_BNE  = 5'b00100;
   localparam logic [4:0] OP_JMP  = 5'b00101;
   localparam logic [4:0] OP_CALL = 5'b00110;
   localparam logic [4:0] OP_RET  = 5'b00111;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [18:0]   pc_q, pc_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          adv_q, adv_d;
   logic          push;
   logic [18:0]   slot_q [STACK_DEPTH];

   logic [4:0]    op;
   logic [18:0]   pc1;
   logic [18:0]   br_tgt;
   logic [18:0]   jmp_tgt;
   logic [AW-1:0] pop_idx;
   logic          full;
   logic          empty;

   assign op      = bus.instr[18:14];
   assign pc1     = pc_q + 19'd1;
   assign br_tgt  = pc1 + {{11{bus.instr[7]}}, bus.instr[7:0]};
   assign jmp_tgt = {5'b0, bus.instr[13:0]};
   assign pop_idx = depth_q[AW-1:0] - 1'b1;
   assign full    = (depth_q == DW'(STACK_DEPTH));
   assign empty   = (depth_q == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         depth_q <= '0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         adv_q   <= adv_d;
      end
   end

   // Stack storage carries no reset; contents are only read below depth_q.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         slot_q[depth_q[AW-1:0]] <= pc1;
      end
   end

   // Next-state / decode
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      adv_d   = 1'b0;
      push    = 1'b0;

      if (state_q != FAULT) begin
         if (bus.stall) begin
            state_d = STALL;
         end else begin
            state_d = RUN;
            adv_d   = 1'b1;
            pc_d    = pc1;
            case (op)
               OP_BEQ:  if (bus.branch_eq)  pc_d = br_tgt;
               OP_BNE:  if (!bus.branch_eq) pc_d = br_tgt;
               OP_JMP:  pc_d = jmp_tgt;
               OP_CALL: begin
                  if (full) begin
`ifdef STACK_FAULT_EN
                     state_d = FAULT;
                     adv_d   = 1'b0;
`else
                     pc_d    = jmp_tgt;
`endif
                  end else begin
                     pc_d    = jmp_tgt;
                     push    = 1'b1;
                     depth_d = depth_q + 1'b1;
                  end
               end
               OP_RET: begin
                  if (empty) begin
`ifdef STACK_FAULT_EN
                     state_d = FAULT;
                     adv_d   = 1'b0;
`else
                     pc_d    = RESET_PC;
`endif
                  end else begin
                     pc_d    = slot_q[pop_idx];
                     depth_d = depth_q - 1'b1;
                  end
               end
               default: pc_d = pc1;
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      bus.pc      = pc_q;
      bus.advance = adv_q;
      bus.depth   = depth_q;
`ifdef STACK_FAULT_EN
      bus.fault   = (state_q == FAULT);
`else
      bus.fault   = 1'b0;
`endif
   end

endmodule
